// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the 64-bit RISC-V pipeline front end.
//
//   XLEN        : architectural register / PC width
//   NOP_INSTR   : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   OPC_BRANCH  : conditional branch major opcode
//   OPC_JAL     : jump-and-link major opcode
//   OPC_JALR    : jump-and-link-register major opcode
//   ifid_entry_t: one fetched {pc, pc4, instr} triple plus predecode flags
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned XLEN = 64;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
   localparam logic [6:0]  OPC_JALR   = 7'b110_0111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [31:0]     instr;
      logic            is_branch;
      logic            is_jump;
   } ifid_entry_t;

endpackage : riscv_pkg

// File: rtl/if_id_predecode.sv
// -----------------------------------------------------------------------------
// if_id_predecode
//   Purely combinational major-opcode classifier. Used by if_id_queue only when
//   IFID_PREDECODE_EN is defined, so the flags are computed once at push time
//   and stored alongside the entry.
//
//   Ports:
//     Opcode   in   7  instr[6:0] of the instruction being pushed
//     IsBranch out  1  opcode is a conditional branch
//     IsJump   out  1  opcode is JAL or JALR
// -----------------------------------------------------------------------------
module if_id_predecode
   import riscv_pkg::*;
(
   input  logic [6:0] Opcode,
   output logic       IsBranch,
   output logic       IsJump
);

   always_comb begin
      IsBranch = 1'b0;
      IsJump   = 1'b0;
      unique case (Opcode)
         OPC_BRANCH:        IsBranch = 1'b1;
         OPC_JAL, OPC_JALR: IsJump   = 1'b1;
         default: ;
      endcase
   end

endmodule : if_id_predecode

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   Decoupling buffer between instruction fetch and decode. Holds up to DEPTH
//   fetched {PC, PC+4, instruction} triples in a circular store and presents
//   them in order under a valid/ready handshake. InReady is derived from the
//   registered occupancy only, so decode stalls never form a combinational
//   path back into fetch. Flush drops everything held and anything offered
//   in the same cycle.
//
//   Build option: define IFID_PREDECODE_EN to classify the opcode at push time
//   and store the branch/jump flags per entry. Without it OutIsBranch and
//   OutIsJump are tied low and no predecode state exists.
//
//   Parameters:
//     DEPTH  number of entries, power of two, >= 2
//     XLEN   PC width
//
//   Ports:
//     Clk         in   1     pipeline clock, rising edge
//     Reset       in   1     asynchronous, active-high
//     InValid     in   1     fetch offers a triple
//     InReady     out  1     space available (count < DEPTH)
//     InPC        in   XLEN  PC of fetched instruction
//     InPC4       in   XLEN  PC+4
//     InInstr     in   32    fetched instruction word
//     Flush       in   1     redirect: drop held and incoming entries
//     OutValid    out  1     head entry valid
//     OutReady    in   1     decode consumes head this cycle
//     OutPC       out  XLEN  head PC (0 when empty)
//     OutPC4      out  XLEN  head PC+4 (0 when empty)
//     OutInstr    out  32    head instruction (NOP when empty)
//     OutIsBranch out  1     head is a conditional branch
//     OutIsJump   out  1     head is JAL/JALR
// -----------------------------------------------------------------------------
module if_id_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            InValid,
   output logic            InReady,
   input  logic [XLEN-1:0] InPC,
   input  logic [XLEN-1:0] InPC4,
   input  logic [31:0]     InInstr,
   input  logic            Flush,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [XLEN-1:0] OutPC,
   output logic [XLEN-1:0] OutPC4,
   output logic [31:0]     OutInstr,
   output logic            OutIsBranch,
   output logic            OutIsJump
);

   import riscv_pkg::*;

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // ---------------------------------------------------------------------------
   // Occupancy and pointers
   // ---------------------------------------------------------------------------
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic push;
   logic pop;

   assign InReady  = (count < FULL_CNT);
   assign OutValid = (count != '0);

   // A flushed cycle never writes storage, so the discarded triple cannot
   // overwrite a slot that a later push will reuse.
   assign push = InValid & InReady & ~Flush;
   assign pop  = OutValid & OutReady & ~Flush;

   // DEPTH is a power of two, so pointer wrap is the natural PW-bit rollover.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage (not reset: an entry is only observable once count covers it)
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] pc4_mem   [DEPTH];
   logic [31:0]     instr_mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= InPC;
         pc4_mem[wr_ptr]   <= InPC4;
         instr_mem[wr_ptr] <= InInstr;
      end
   end

`ifdef IFID_PREDECODE_EN
   logic in_is_branch;
   logic in_is_jump;
   logic br_mem [DEPTH];
   logic jp_mem [DEPTH];

   if_id_predecode u_predecode (
      .Opcode   (InInstr[6:0]),
      .IsBranch (in_is_branch),
      .IsJump   (in_is_jump)
   );

   always_ff @(posedge Clk) begin
      if (push) begin
         br_mem[wr_ptr] <= in_is_branch;
         jp_mem[wr_ptr] <= in_is_jump;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Head presentation: idle values whenever the queue is empty
   // ---------------------------------------------------------------------------
   always_comb begin
      OutPC       = '0;
      OutPC4      = '0;
      OutInstr    = NOP_INSTR;
      OutIsBranch = 1'b0;
      OutIsJump   = 1'b0;
      if (OutValid) begin
         OutPC    = pc_mem[rd_ptr];
         OutPC4   = pc4_mem[rd_ptr];
         OutInstr = instr_mem[rd_ptr];
`ifdef IFID_PREDECODE_EN
         OutIsBranch = br_mem[rd_ptr];
         OutIsJump   = jp_mem[rd_ptr];
`endif
      end
   end

endmodule : if_id_queue

// File: doc/if_id_queue.md
# if_id_queue

Decoupling buffer between the instruction fetch unit and the decode stage of the 64-bit RISC-V pipeline. It captures each fetched {PC, PC+4, instruction} triple, holds up to DEPTH entries, and presents them in order to decode under a valid/ready handshake. It absorbs decode stalls without a combinational path back into fetch, and discards all in-flight instructions on a branch/jump flush.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- XLEN, 64, PC width
- Clk  input  1  pipeline clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- InValid  input  1  fetch presents a valid triple this cycle
- InReady  output  1  queue can accept; drives fetch's PCWrite
- InPC  input  XLEN  PC of fetched instruction (PCNow)
- InPC4  input  XLEN  PC+4 (PCNext4)
- InInstr  input  32  fetched instruction word
- Flush  input  1  redirect taken; drop all held and incoming entries
- OutValid  output  1  head entry valid
- OutReady  input  1  decode accepts head this cycle
- OutPC  output  XLEN  head PC
- OutPC4  output  XLEN  head PC+4
- OutInstr  output  32  head instruction; 32'h00000013 (NOP) when OutValid=0
- OutIsBranch  output  1  head opcode is 7'b1100011
- OutIsJump  output  1  head opcode is 7'b1101111 or 7'b1100111

## Operation
- Push = InValid & InReady; pop = OutValid & OutReady.
- InReady = (count < DEPTH); depends only on registered count, never on OutReady.
- Circular storage with write pointer, read pointer, count (0..DEPTH); pointers wrap modulo DEPTH.
- Push writes triple at write pointer, advances it, count+1. Pop advances read pointer, count-1. Push+pop same cycle: count unchanged, both pointers advance.
- OutValid = (count != 0). Out* taken from entry at read pointer; when empty, OutPC/OutPC4 = 0, OutInstr = NOP, flags = 0.
- Flush (priority over push and pop): pointers and count to 0 next edge; any push that cycle is discarded; pop that cycle has no effect beyond the clear.
- Full: InReady=0, InValid ignored, stored data unchanged.
- Empty with OutReady=1: no pop, count stays 0.

## Timing
- Reset values: count 0, pointers 0, OutValid 0, InReady 1, OutPC 0, OutPC4 0, OutInstr 32'h00000013, OutIsBranch 0, OutIsJump 0.
- Reset is asynchronous assert; state held while Reset=1; first push accepted on first edge after deassertion.
- Latency: entry pushed at edge N is visible on Out* after edge N (no same-cycle bypass).
- Throughput: one push and one pop per cycle sustained at any count 1..DEPTH-1.
- After Flush at edge N: OutValid=0 and InReady=1 after edge N.
- Storage contents need no reset; only pointers/count are reset.

## Configuration
- IFID_PREDECODE_EN defined: opcode classification computed at push time and stored per entry; OutIsBranch/OutIsJump reflect head entry.
- Not defined: no predecode storage or logic; OutIsBranch and OutIsJump tied to 0. Ports exist in both builds.

## Structure
- Shared package riscv_pkg: XLEN, NOP_INSTR (32'h00000013), OPC_BRANCH, OPC_JAL, OPC_JALR constants, entry struct {pc, pc4, instr, is_branch, is_jump}.
- One sub-module: if_id_predecode (combinational opcode classifier), instantiated only under IFID_PREDECODE_EN.

## Test plan
- Reset mid-stream with count=2 -> OutValid=0, InReady=1, OutInstr=32'h00000013 immediately, before next edge.
- Push PC=0x0,0x4,0x8 on consecutive cycles with OutReady=0 (DEPTH=2) -> InReady=0 after second edge, third dropped, then OutReady=1 yields PC 0x0 then 0x4 in order.
- Continuous InValid=1, OutReady=1 from empty -> first OutValid one cycle after first push, then one entry out per cycle, count stays 1, pointers wrap with no loss.
- Count=2 plus simultaneous InValid and Flush -> after edge OutValid=0, InReady=1, next push appears as sole head entry.
- With IFID_PREDECODE_EN push 32'h00000063 then 32'h0000006F -> OutIsBranch=1 then OutIsJump=1; without macro both stay 0.
- Empty queue with OutReady=1 for 5 cycles -> count remains 0, no underflow, pointers unchanged.
